ahb_arbiter: RTL and testbench

Central AHB bus arbiter for the integration fabric. It samples per-master `hbusreq`/`hlock` and produces a one-hot `hgrant`, the address-phase owner `hmaster`, and `hmastlock`. It sits directly upstream of the master-side and slave-side bus interfaces. Those interfaces consume its grant and ownership outputs and feed back the muxed `htrans`/`hburst` and the shared `hready`/`hresp`. Arbitration is round-robin and burst-aware: a fixed-length burst is never split, and a locked sequence is never interrupted.

---
 rtl/integration_pkg.sv | 47 ++++
 rtl/ahb_rr_picker.sv | 34 +++
 rtl/ahb_arbiter.sv | 92 +++++++++
 tb/tb_ahb_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/integration_pkg.sv
// rtl/integration_pkg.sv - shared AHB encodings and arbiter grant-state type
package integration_pkg;

    localparam int HMASTER_W = 4;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_t;

    typedef enum logic [1:0] {
        GS_OPEN   = 2'd0,
        GS_BURST  = 2'd1,
        GS_LOCKED = 2'd2
    } gstate_t;

    // Address phases still to come after the NONSEQ of a fixed burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats(input logic [2:0] burst);
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  burst_beats = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  burst_beats = 4'd7;
            BURST_WRAP16, BURST_INCR16: burst_beats = 4'd15;
            default:                    burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - round-robin winner search starting after the current grantee
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [3:0]             cur,
    input  logic [3:0]             dflt,
    output logic [3:0]             win
);

    logic [4:0]             idx;
    logic [NUM_MASTERS-1:0] sel;
    logic                   found;

    // Offset NUM_MASTERS lands back on cur, so a lone current requester keeps the bus.
    always_comb begin
        win   = dflt;
        found = 1'b0;
        idx   = 5'd0;
        sel   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = {1'b0, cur} + 5'(i);
            if (idx >= 5'(NUM_MASTERS)) begin
                idx = idx - 5'(NUM_MASTERS);
            end
            sel = req >> idx;
            if (!found && sel[0]) begin
                found = 1'b1;
                win   = idx[3:0];
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - burst- and lock-aware round-robin AHB arbiter
module ahb_arbiter
    import integration_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [HMASTER_W-1:0]   hmaster,
    output logic                   hmastlock
);

    localparam logic [3:0]             DEF_IDX = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] ONE     = NUM_MASTERS'(1);

    gstate_t                gstate;
    logic [3:0]             gidx;
    logic [3:0]             cnt;
    logic [3:0]             cnt_next;
    logic [3:0]             winner;
    logic [NUM_MASTERS-1:0] lock_vec;
    logic                   lock_now;
    logic                   is_seq;
    logic                   fixed_nonseq;
    logic                   err;
    logic                   may_rearb;

    ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req  (hbusreq),
        .cur  (gidx),
        .dflt (DEF_IDX),
        .win  (winner)
    );

    always_comb begin
        lock_vec     = hlock >> gidx;
        lock_now     = lock_vec[0];
        is_seq       = (htrans == TRANS_SEQ);
        fixed_nonseq = (htrans == TRANS_NONSEQ) && (burst_beats(hburst) != 4'd0);
        err          = (hresp != RESP_OKAY);

        if (err) begin
            cnt_next = 4'd0;
        end else if (fixed_nonseq) begin
            cnt_next = burst_beats(hburst);
        end else if (is_seq && cnt != 4'd0) begin
            cnt_next = cnt - 4'd1;
        end else begin
            cnt_next = cnt;
        end

        // A lock request arriving on the burst's last beat keeps the bus with the grantee.
        may_rearb = !fixed_nonseq && !lock_now && (gstate != GS_LOCKED) &&
                    (err || cnt == 4'd0 || (cnt == 4'd1 && is_seq));
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            gstate    <= GS_OPEN;
            cnt       <= 4'd0;
            gidx      <= DEF_IDX;
            hgrant    <= ONE << DEF_IDX;
            hmaster   <= DEF_IDX;
            hmastlock <= 1'b0;
        end else if (hready) begin
            cnt       <= cnt_next;
            hmaster   <= gidx;
            hmastlock <= lock_now;
            // Leaving LOCKED mid-burst falls back to BURST so the counter still guards the handover.
            if (lock_now) begin
                gstate <= GS_LOCKED;
            end else if (cnt_next != 4'd0) begin
                gstate <= GS_BURST;
            end else begin
                gstate <= GS_OPEN;
            end
            if (may_rearb) begin
                gidx   <= winner;
                hgrant <= ONE << winner;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for ahb_arbiter
module tb_ahb_arbiter;
    import integration_pkg::*;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] master;
        logic       mlock;
    } exp_t;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the expected post-edge outputs, then compare after the edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [1:0] rs, input int eg, input int em, input logic el);
        exp_t e;
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        hresp   = rs;
        e.grant  = 4'b0001 << eg;
        e.master = 4'(em);
        e.mlock  = el;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_grant"},  32'(hgrant),    32'(e.grant));
            chk({tag, "_master"}, 32'(hmaster),   32'(e.master));
            chk({tag, "_mlock"},  32'(hmastlock), 32'(e.mlock));
        end
    endtask

    initial begin
        hreset  = 1'b1;
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = TRANS_IDLE;
        hburst  = BURST_SINGLE;
        hready  = 1'b1;
        hresp   = RESP_OKAY;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_grant",  32'(hgrant),    32'h1);
        chk("reset_master", 32'(hmaster),   32'h0);
        chk("reset_mlock",  32'(hmastlock), 32'h0);
        hreset = 1'b0;

        // Rotation
        cyc("rot1", 4'b1111, 4'b0, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 1, 0, 0);
        cyc("rot2", 4'b1111, 4'b0, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 2, 1, 0);
        cyc("rot3", 4'b1111, 4'b0, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 3, 2, 0);
        cyc("rot4", 4'b1111, 4'b0, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 0, 3, 0);
        cyc("rot5", 4'b1111, 4'b0, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 1, 0, 0);
        cyc("idle1", 4'b0000, 4'b0, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 0, 1, 0);
        cyc("idle2", 4'b0000, 4'b0, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 0, 0, 0);

        // Burst integrity: master 2 INCR8, master 1 requests from beat 2
        cyc("b8_grant", 4'b0100, 4'b0, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 2, 0, 0);
        cyc("b8_ns",    4'b0100, 4'b0, TRANS_NONSEQ, BURST_INCR8,  1, RESP_OKAY, 2, 2, 0);
        for (int i = 0; i < 6; i++) begin
            cyc("b8_seq", 4'b0110, 4'b0, TRANS_SEQ, BURST_INCR8, 1, RESP_OKAY, 2, 2, 0);
        end
        cyc("b8_last", 4'b0110, 4'b0, TRANS_SEQ,  BURST_INCR8,  1, RESP_OKAY, 1, 2, 0);
        cyc("b8_own",  4'b0010, 4'b0, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 1, 1, 0);

        // Wait states mid-WRAP4 and right after a handover
        cyc("w4_ns",   4'b0011, 4'b0, TRANS_NONSEQ, BURST_WRAP4, 1, RESP_OKAY, 1, 1, 0);
        cyc("w4_s1",   4'b0011, 4'b0, TRANS_SEQ,    BURST_WRAP4, 1, RESP_OKAY, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("w4_wait", 4'b0011, 4'b0, TRANS_SEQ, BURST_WRAP4, 0, RESP_OKAY, 1, 1, 0);
        end
        cyc("w4_s2",   4'b0011, 4'b0, TRANS_SEQ,    BURST_WRAP4, 1, RESP_OKAY, 1, 1, 0);
        cyc("w4_s3",   4'b0011, 4'b0, TRANS_SEQ,    BURST_WRAP4, 1, RESP_OKAY, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc("w4_hold", 4'b0001, 4'b0, TRANS_IDLE, BURST_SINGLE, 0, RESP_OKAY, 0, 1, 0);
        end
        cyc("w4_own",  4'b0001, 4'b0, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 0, 0, 0);

        // Lock: master 3 locked over two INCR4 bursts while master 0 requests
        cyc("lk_grant", 4'b1000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 3, 0, 0);
        for (int b = 0; b < 2; b++) begin
            cyc("lk_ns", 4'b1001, 4'b1000, TRANS_NONSEQ, BURST_INCR4, 1, RESP_OKAY, 3, 3, 1);
            for (int i = 0; i < 3; i++) begin
                cyc("lk_seq", 4'b1001, 4'b1000, TRANS_SEQ, BURST_INCR4, 1, RESP_OKAY, 3, 3, 1);
            end
        end
        cyc("lk_drop", 4'b1001, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 3, 3, 0);
        cyc("lk_move", 4'b0001, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 0, 3, 0);
        cyc("lk_own",  4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 0, 0, 0);

        // Error abort: RETRY on beat 2 of INCR16
        cyc("er_ns",    4'b0001, 4'b0, TRANS_NONSEQ, BURST_INCR16, 1, RESP_OKAY,  0, 0, 0);
        cyc("er_retry", 4'b0101, 4'b0, TRANS_SEQ,    BURST_INCR16, 1, RESP_RETRY, 2, 0, 0);
        cyc("er_open",  4'b0101, 4'b0, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY,  0, 2, 0);
        cyc("er_own",   4'b0000, 4'b0, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY,  0, 0, 0);

        // Asynchronous reset mid-burst
        cyc("rs_grant", 4'b0100, 4'b0, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 2, 0, 0);
        cyc("rs_ns",    4'b0110, 4'b0, TRANS_NONSEQ, BURST_INCR4,  1, RESP_OKAY, 2, 2, 0);
        #2;
        hreset = 1'b1;
        #1;
        chk("arst_grant",  32'(hgrant),    32'h1);
        chk("arst_master", 32'(hmaster),   32'h0);
        chk("arst_mlock",  32'(hmastlock), 32'h0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        cyc("rs_after", 4'b0110, 4'b0, TRANS_SEQ, BURST_INCR4, 1, RESP_OKAY, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
